// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among four byte-stream clients. Clients are
//   served round-robin. A client whose byte is not marked last keeps the
//   transmitter locked until it sends its last byte. If the owner stalls for
//   too long, the lock is dropped.
//
// Ports
//   sys_clk       sole clock, rising edge
//   sys_rst       asynchronous active-high reset
//   req_valid[i]  client i has a byte on req_data[8i+7:8i]
//   req_last[i]   that byte closes client i's packet
//   req_ready[i]  one-cycle strobe: client i's byte has been taken
//   tx_data       byte to the transmitter, valid with tx_wr
//   tx_wr         one-cycle write strobe to the transmitter
//   tx_done       one-cycle completion pulse from the transmitter
//   busy          arbiter is not idle
//   locked        a packet is open and only its owner may be granted
//   owner         index of the most recently granted client
//   lock_timeout  one-cycle pulse when a stalled lock is released
module uart_tx_arbiter #(
    parameter logic [15:0] LOCK_TIMEOUT = 16'd1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_done,
    output logic        busy,
    output logic        locked,
    output logic [1:0]  owner,
    output logic        lock_timeout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        HOLD      = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_wr_q, tx_wr_d;
    logic [3:0]  req_ready_q, req_ready_d;
    logic        busy_q, busy_d;
    logic        locked_q, locked_d;
    logic [1:0]  owner_q, owner_d;
    logic        lock_timeout_q, lock_timeout_d;

    logic        grant;
    logic [1:0]  gnt_idx;
    logic [2:0]  pick;

    // Returns {found, index} of the first valid client scanning ptr, ptr+1, ...
    // The scan runs from the farthest offset down, so the nearest hit wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] vld, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (vld[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        cnt_d          = cnt_q;
        last_d         = last_q;
        tx_data_d      = tx_data_q;
        tx_wr_d        = 1'b0;
        req_ready_d    = 4'b0000;
        locked_d       = locked_q;
        owner_d        = owner_q;
        lock_timeout_d = 1'b0;
        grant          = 1'b0;
        gnt_idx        = owner_q;
        pick           = rr_pick(req_valid, rr_ptr_q);

        case (state_q)
            IDLE: begin
                if (pick[2]) begin
                    grant   = 1'b1;
                    gnt_idx = pick[1:0];
                end
            end
            WAIT_DONE: begin
                // A tx_done during the tx_wr cycle belongs to an earlier
                // write. Only a later pulse completes this byte.
                if (tx_done && !tx_wr_q) begin
                    if (last_q) begin
                        locked_d = 1'b0;
                        rr_ptr_d = owner_q + 2'd1;
                        state_d  = IDLE;
                    end else begin
                        locked_d = 1'b1;
                        cnt_d    = 16'd0;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                // The owner's request takes priority over expiry in the same cycle.
                if (req_valid[owner_q]) begin
                    grant   = 1'b1;
                    gnt_idx = owner_q;
                end else if (cnt_q == LOCK_TIMEOUT - 16'd1) begin
                    lock_timeout_d = 1'b1;
                    locked_d       = 1'b0;
                    rr_ptr_d       = owner_q + 2'd1;
                    state_d        = IDLE;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant) begin
            tx_data_d   = req_data[{gnt_idx, 3'b000} +: 8];
            owner_d     = gnt_idx;
            last_d      = req_last[gnt_idx];
            tx_wr_d     = 1'b1;
            req_ready_d = 4'b0001 << gnt_idx;
            // A non-last byte opens the packet. Once a packet is open, it stays
            // open until its last byte completes.
            locked_d    = locked_q | ~req_last[gnt_idx];
            cnt_d       = 16'd0;
            state_d     = WAIT_DONE;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q        <= IDLE;
            rr_ptr_q       <= 2'd0;
            cnt_q          <= 16'd0;
            last_q         <= 1'b0;
            tx_data_q      <= 8'h00;
            tx_wr_q        <= 1'b0;
            req_ready_q    <= 4'b0000;
            busy_q         <= 1'b0;
            locked_q       <= 1'b0;
            owner_q        <= 2'd0;
            lock_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            cnt_q          <= cnt_d;
            last_q         <= last_d;
            tx_data_q      <= tx_data_d;
            tx_wr_q        <= tx_wr_d;
            req_ready_q    <= req_ready_d;
            busy_q         <= busy_d;
            locked_q       <= locked_d;
            owner_q        <= owner_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign tx_data      = tx_data_q;
    assign tx_wr        = tx_wr_q;
    assign busy         = busy_q;
    assign locked       = locked_q;
    assign owner        = owner_q;
    assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter, built with LOCK_TIMEOUT = 8.
// Outputs are packed as {tx_wr, req_ready, tx_data, busy, locked, owner, lock_timeout}.
// They are sampled on the falling clock edge.
module tb_uart_tx_arbiter;

    logic        sys_clk;
    logic        sys_rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_done;
    logic        busy;
    logic        locked;
    logic [1:0]  owner;
    logic        lock_timeout;

    logic [17:0] obs;
    logic [17:0] exp_v;
    int          vectors;
    int          miscompares;

    uart_tx_arbiter #(.LOCK_TIMEOUT(16'd8)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_wr        (tx_wr),
        .tx_done      (tx_done),
        .busy         (busy),
        .locked       (locked),
        .owner        (owner),
        .lock_timeout (lock_timeout)
    );

    assign obs = {tx_wr, req_ready, tx_data, busy, locked, owner, lock_timeout};

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge sys_clk);
        sys_rst   = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        req_last  = 4'b0000;
        tx_done   = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    // One-cycle tx_done pulse; returns at the falling edge after it was sampled.
    task automatic do_done();
        tx_done = 1'b1;
        @(negedge sys_clk);
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b0; req_valid = 4'b0000; req_data = 32'h0; req_last = 4'b0000; tx_done = 1'b0;
        #1 sys_rst = 1'b1;
        #1;
        exp_v = {1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL reset_state: obs=%h exp=%h", obs, exp_v); end
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        req_valid = 4'b0100; req_data[23:16] = 8'h41; req_last = 4'b0100;
        @(negedge sys_clk);
        exp_v = {1'b1, 4'b0100, 8'h41, 1'b1, 1'b0, 2'd2, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL single_grant: obs=%h exp=%h", obs, exp_v); end
        req_valid = 4'b0000;
        @(negedge sys_clk);
        exp_v = {1'b0, 4'b0000, 8'h41, 1'b1, 1'b0, 2'd2, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL single_strobe_width: obs=%h exp=%h", obs, exp_v); end
        do_done();
        exp_v = {1'b0, 4'b0000, 8'h41, 1'b0, 1'b0, 2'd2, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL single_idle: obs=%h exp=%h", obs, exp_v); end
        // Pointer now 3: client 3 must beat client 0.
        req_valid = 4'b1001; req_data[7:0] = 8'h30; req_data[31:24] = 8'h33; req_last = 4'b1001;
        @(negedge sys_clk);
        exp_v = {1'b1, 4'b1000, 8'h33, 1'b1, 1'b0, 2'd3, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL single_rrptr3: obs=%h exp=%h", obs, exp_v); end
        req_valid = 4'b0001;
        @(negedge sys_clk);
        do_done();
        exp_v = {1'b0, 4'b0000, 8'h33, 1'b0, 1'b0, 2'd3, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL single_idle2: obs=%h exp=%h", obs, exp_v); end
        @(negedge sys_clk);
        exp_v = {1'b1, 4'b0001, 8'h30, 1'b1, 1'b0, 2'd0, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL single_wrap0: obs=%h exp=%h", obs, exp_v); end
        req_valid = 4'b0000;
        @(negedge sys_clk);
        do_done();
    endtask

    task automatic test_round_robin();
        apply_reset();
        req_valid = 4'b1111; req_data = 32'h13121110; req_last = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            exp_v = {1'b1, 4'(4'b0001 << k), 8'(8'h10 + k), 1'b1, 1'b0, 2'(k), 1'b0};
            vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL rr_grant k=%0d: obs=%h exp=%h", k, obs, exp_v); end
            req_valid[k] = 1'b0;
            @(negedge sys_clk);
            @(negedge sys_clk);
            exp_v = {1'b0, 4'b0000, 8'(8'h10 + k), 1'b1, 1'b0, 2'(k), 1'b0};
            vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL rr_no_rewrite k=%0d: obs=%h exp=%h", k, obs, exp_v); end
            do_done();
        end
        exp_v = {1'b0, 4'b0000, 8'h13, 1'b0, 1'b0, 2'd3, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL rr_final_idle: obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_packet_lock();
        apply_reset();
        req_valid = 4'b0010; req_data[15:8] = 8'hAA; req_last = 4'b0000;
        @(negedge sys_clk);
        exp_v = {1'b1, 4'b0010, 8'hAA, 1'b1, 1'b1, 2'd1, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL pkt_aa: obs=%h exp=%h", obs, exp_v); end
        req_data[15:8] = 8'hBB; req_data[7:0] = 8'h77; req_last = 4'b0001; req_valid = 4'b0011;
        @(negedge sys_clk);
        do_done();
        exp_v = {1'b0, 4'b0000, 8'hAA, 1'b1, 1'b1, 2'd1, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL pkt_hold: obs=%h exp=%h", obs, exp_v); end
        @(negedge sys_clk);
        exp_v = {1'b1, 4'b0010, 8'hBB, 1'b1, 1'b1, 2'd1, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL pkt_bb: obs=%h exp=%h", obs, exp_v); end
        req_data[15:8] = 8'hCC; req_last = 4'b0011;
        @(negedge sys_clk);
        do_done();
        @(negedge sys_clk);
        exp_v = {1'b1, 4'b0010, 8'hCC, 1'b1, 1'b1, 2'd1, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL pkt_cc: obs=%h exp=%h", obs, exp_v); end
        req_valid = 4'b0001;
        @(negedge sys_clk);
        do_done();
        exp_v = {1'b0, 4'b0000, 8'hCC, 1'b0, 1'b0, 2'd1, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL pkt_unlock: obs=%h exp=%h", obs, exp_v); end
        @(negedge sys_clk);
        exp_v = {1'b1, 4'b0001, 8'h77, 1'b1, 1'b0, 2'd0, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL pkt_client0: obs=%h exp=%h", obs, exp_v); end
        req_valid = 4'b0000;
        @(negedge sys_clk);
        do_done();
    endtask

    task automatic test_timeout();
        apply_reset();
        req_valid = 4'b1000; req_data[31:24] = 8'h55; req_last = 4'b0000;
        @(negedge sys_clk);
        exp_v = {1'b1, 4'b1000, 8'h55, 1'b1, 1'b1, 2'd3, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL tmo_grant: obs=%h exp=%h", obs, exp_v); end
        req_valid = 4'b0000;
        @(negedge sys_clk);
        do_done();
        // Client 0 waits while client 3 holds the lock; a stray tx_done is also ignored.
        req_valid = 4'b0001; req_data[7:0] = 8'h0C; req_last = 4'b0001;
        for (int i = 1; i <= 7; i++) begin
            @(negedge sys_clk);
            exp_v = {1'b0, 4'b0000, 8'h55, 1'b1, 1'b1, 2'd3, 1'b0};
            vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL tmo_hold i=%0d: obs=%h exp=%h", i, obs, exp_v); end
            tx_done = (i == 3);
        end
        @(negedge sys_clk);
        exp_v = {1'b0, 4'b0000, 8'h55, 1'b0, 1'b0, 2'd3, 1'b1};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL tmo_pulse: obs=%h exp=%h", obs, exp_v); end
        @(negedge sys_clk);
        exp_v = {1'b1, 4'b0001, 8'h0C, 1'b1, 1'b0, 2'd0, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL tmo_next_client0: obs=%h exp=%h", obs, exp_v); end
        req_valid = 4'b0000;
        @(negedge sys_clk);
        do_done();
    endtask

    task automatic test_expiry_grant();
        apply_reset();
        req_valid = 4'b0100; req_data[23:16] = 8'h21; req_last = 4'b0000;
        @(negedge sys_clk);
        req_valid = 4'b0000;
        @(negedge sys_clk);
        do_done();
        for (int i = 1; i <= 7; i++) begin
            @(negedge sys_clk);
            exp_v = {1'b0, 4'b0000, 8'h21, 1'b1, 1'b1, 2'd2, 1'b0};
            vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL exp_hold i=%0d: obs=%h exp=%h", i, obs, exp_v); end
        end
        req_valid = 4'b0100; req_data[23:16] = 8'h22; req_last = 4'b0100;
        @(negedge sys_clk);
        exp_v = {1'b1, 4'b0100, 8'h22, 1'b1, 1'b1, 2'd2, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL exp_owner_wins: obs=%h exp=%h", obs, exp_v); end
        req_valid = 4'b0000;
        @(negedge sys_clk);
        do_done();
        exp_v = {1'b0, 4'b0000, 8'h22, 1'b0, 1'b0, 2'd2, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL exp_release: obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req_valid = 4'b0010; req_data[15:8] = 8'h5A; req_last = 4'b0000;
        @(negedge sys_clk);
        exp_v = {1'b1, 4'b0010, 8'h5A, 1'b1, 1'b1, 2'd1, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL rstmid_grant: obs=%h exp=%h", obs, exp_v); end
        req_valid = 4'b0000;
        @(negedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        exp_v = {1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL rstmid_async: obs=%h exp=%h", obs, exp_v); end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        do_done();
        @(negedge sys_clk);
        @(negedge sys_clk);
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL rstmid_no_wr: obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_done_ignored();
        apply_reset();
        do_done();
        exp_v = {1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL done_idle: obs=%h exp=%h", obs, exp_v); end
        req_valid = 4'b0001; req_data[7:0] = 8'h99; req_last = 4'b0001;
        @(negedge sys_clk);
        tx_done = 1'b1; req_valid = 4'b0000;
        @(negedge sys_clk);
        tx_done = 1'b0;
        exp_v = {1'b0, 4'b0000, 8'h99, 1'b1, 1'b0, 2'd0, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL done_on_wr: obs=%h exp=%h", obs, exp_v); end
        @(negedge sys_clk);
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL done_still_wait: obs=%h exp=%h", obs, exp_v); end
        do_done();
        exp_v = {1'b0, 4'b0000, 8'h99, 1'b0, 1'b0, 2'd0, 1'b0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL done_complete: obs=%h exp=%h", obs, exp_v); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_timeout();
        test_expiry_grant();
        test_reset_mid();
        test_done_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
